// File: rtl/ysyx_24090012_regfile_wbq.sv
// Register file with a write-back queue in front of it.
// Reads forward from pending entries; retire updates rf and pc.
module ysyx_24090012_regfile_wbq #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 32,
  parameter int          NREG       = 16,
  parameter int          WB_DEPTH   = 1,
  parameter logic [31:0] RESET_PC   = 32'h3000_0000,
  localparam int         CW = $clog2(WB_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [31:0]           next_pc,
  input  logic                  commit_en,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic [31:0]           pc,
  output logic [CW-1:0]         wb_count,
  output logic [31:0]           retire_cnt
);

  localparam int IW = $clog2(NREG);
  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

  logic                  q_wen  [WB_DEPTH];
  logic [IW-1:0]         q_idx  [WB_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [WB_DEPTH];
  logic [31:0]           q_pc   [WB_DEPTH];

  logic [DATA_WIDTH-1:0] rf [NREG];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(WB_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign rd_ready = (count < CW'(WB_DEPTH));
  assign wb_count = count;
  assign push     = rd_valid && rd_ready;
  assign pop      = commit_en && (count != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      pc         <= RESET_PC;
      retire_cnt <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (push) begin
        tail <= nxt(tail);
      end
      if (pop) begin
        head       <= nxt(head);
        pc         <= q_pc[head];
        retire_cnt <= retire_cnt + 32'd1;
        if (q_wen[head] && (q_idx[head] != '0)) begin
          rf[q_idx[head]] <= q_data[head];
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_wen[tail]  <= wen;
      q_idx[tail]  <= waddr[IW-1:0];
      q_data[tail] <= wdata;
      q_pc[tail]   <= next_pc;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] lookup(
    input logic [IW-1:0] ri
  );
    logic [DATA_WIDTH-1:0] r;
    int                    s;
    r = rf[ri];
    for (int i = 0; i < WB_DEPTH; i++) begin
      s = int'(head) + i;
      if (s >= WB_DEPTH) s = s - WB_DEPTH;
      if ((i < int'(count)) && q_wen[s]
          && (q_idx[s] == ri)) begin
        r = q_data[s];
      end
    end
    if (ri == '0) r = '0;
    return r;
  endfunction

  assign rdata1 = lookup(raddr1[IW-1:0]);
  assign rdata2 = lookup(raddr2[IW-1:0]);

  generate
    if (ADDR_WIDTH > IW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{raddr1[ADDR_WIDTH-1:IW],
                           raddr2[ADDR_WIDTH-1:IW],
                           waddr[ADDR_WIDTH-1:IW]};
    end
  endgenerate

`ifndef SYNTHESIS
  function int get_reg_value(input int idx);
    return int'(rf[IW'(idx)]);
  endfunction
`endif

endmodule

// File: tb/tb_ysyx_24090012_regfile_wbq.sv
// Bench for ysyx_24090012_regfile_wbq: depth-1 and depth-4
// instances checked against a queue scoreboard.
module tb_ysyx_24090012_regfile_wbq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset0, reset1, v0, v1, ce0, ce1;
  logic        wen;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, next_pc;
  logic        rdy0, rdy1;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic [31:0] pc0, pc1, rc0, rc1;
  logic [0:0]  wbc0;
  logic [2:0]  wbc1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic [3:0]  idx;
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  ent_t        q0[$];
  ent_t        q1[$];
  logic [31:0] mrf0[16];
  logic [31:0] mrf1[16];
  logic [31:0] mpc0, mpc1, mrc0, mrc1;

  ysyx_24090012_regfile_wbq #(.WB_DEPTH(1)) u0 (
    .clock(clock), .reset(reset0),
    .rd_valid(v0), .rd_ready(rdy0),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .next_pc(next_pc), .commit_en(ce0),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_0), .rdata2(rd2_0),
    .pc(pc0), .wb_count(wbc0), .retire_cnt(rc0)
  );

  ysyx_24090012_regfile_wbq #(.WB_DEPTH(4)) u1 (
    .clock(clock), .reset(reset1),
    .rd_valid(v1), .rd_ready(rdy1),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .next_pc(next_pc), .commit_en(ce1),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_1), .rdata2(rd2_1),
    .pc(pc1), .wb_count(wbc1), .retire_cnt(rc1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic mreset(input int u);
    if (u == 0) begin
      q0.delete();
      mpc0 = 32'h3000_0000;
      mrc0 = 0;
      foreach (mrf0[i]) mrf0[i] = '0;
    end else begin
      q1.delete();
      mpc1 = 32'h3000_0000;
      mrc1 = 0;
      foreach (mrf1[i]) mrf1[i] = '0;
    end
  endtask

  function automatic logic [31:0] mfwd(input int u,
                                       input logic [4:0] a);
    logic [31:0] r;
    if (u == 0) begin
      r = mrf0[a[3:0]];
      foreach (q0[i])
        if (q0[i].wen && q0[i].idx == a[3:0]) r = q0[i].d;
    end else begin
      r = mrf1[a[3:0]];
      foreach (q1[i])
        if (q1[i].wen && q1[i].idx == a[3:0]) r = q1[i].d;
    end
    if (a[3:0] == 4'd0) r = '0;
    return r;
  endfunction

  // one clock of traffic on unit u, checked against the model
  task automatic cyc(input int u, input logic v,
                     input logic we, input logic [4:0] a,
                     input logic [31:0] d,
                     input logic [31:0] np,
                     input logic ce, output logic acc);
    ent_t e;
    ent_t r;
    int   sz;
    int   dep;
    logic ret;
    wen = we; waddr = a; wdata = d; next_pc = np;
    if (u == 0) begin v0 = v; ce0 = ce; end
    else        begin v1 = v; ce1 = ce; end
    sz  = (u == 0) ? q0.size() : q1.size();
    dep = (u == 0) ? 1 : 4;
    chk("rd_ready", (u == 0) ? rdy0 : rdy1,
        32'(sz < dep));
    acc = v && (sz < dep);
    ret = ce && (sz != 0);
    e.wen = we; e.idx = a[3:0]; e.d = d; e.pc = np;
    r = e;
    if (u == 0) begin
      if (ret) begin
        r = q0.pop_front();
        mpc0 = r.pc; mrc0++;
        if (r.wen && r.idx != 0) mrf0[r.idx] = r.d;
      end
      if (acc) q0.push_back(e);
    end else begin
      if (ret) begin
        r = q1.pop_front();
        mpc1 = r.pc; mrc1++;
        if (r.wen && r.idx != 0) mrf1[r.idx] = r.d;
      end
      if (acc) q1.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    v0 = 0; v1 = 0; ce0 = 0; ce1 = 0;
    if (u == 0) begin
      chk("pc", pc0, mpc0);
      chk("retire_cnt", rc0, mrc0);
      chk("wb_count", 32'(wbc0), 32'(q0.size()));
      if (ret) chk("rf", u0.rf[r.idx], mrf0[r.idx]);
    end else begin
      chk("pc", pc1, mpc1);
      chk("retire_cnt", rc1, mrc1);
      chk("wb_count", 32'(wbc1), 32'(q1.size()));
      if (ret) chk("rf", u1.rf[r.idx], mrf1[r.idx]);
    end
  endtask

  task automatic rd(input int u, input logic [4:0] a,
                    input logic [31:0] exp,
                    input string tag);
    raddr1 = a;
    raddr2 = a;
    #1;
    chk(tag, (u == 0) ? rd1_0 : rd1_1, exp);
    chk({tag, "_r2"}, (u == 0) ? rd2_0 : rd2_1,
        mfwd(u, a));
  endtask

  // issue one request, holding valid until accepted
  task automatic req(input int u, input logic we,
                     input logic [4:0] a,
                     input logic [31:0] d,
                     input logic [31:0] np,
                     input logic ce);
    logic acc;
    int   n;
    n = 0;
    acc = 0;
    while (!acc && n < 8) begin
      cyc(u, 1'b1, we, a, d, np, ce, acc);
      n++;
    end
    chk("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int u, input logic ce);
    logic acc;
    cyc(u, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, ce, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    logic [31:0] rcb;
    reset0 = 1; reset1 = 1;
    v0 = 0; v1 = 0; ce0 = 0; ce1 = 0;
    wen = 0; waddr = 0; wdata = 0; next_pc = 0;
    raddr1 = 0; raddr2 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset0 = 0; reset1 = 0;
    mreset(0); mreset(1);
    chk("rst_pc0", pc0, 32'h3000_0000);
    chk("rst_rdy0", 32'(rdy0), 32'd1);
    chk("rst_wbc1", 32'(wbc1), 32'd0);
    chk("rst_rc1", rc1, 32'd0);

    // depth 1: back-to-back writes x1..x4
    for (int k = 1; k <= 4; k++)
      req(0, 1'b1, 5'(k), 32'(k * 'h11),
          32'h3000_0000 + 32'(4 * k), 1'b1);
    idle(0, 1'b1);
    chk("d1_pc", pc0, 32'h3000_0010);
    chk("d1_rf4", u0.rf[4], 32'h44);
    chk("d1_rc", rc0, 32'd4);

    // depth 4 backpressure
    for (int k = 1; k <= 5; k++)
      cyc(1, 1'b1, 1'b1, 5'(k), 32'h100 + 32'(k),
          32'h3000_0000 + 32'(4 * k), 1'b0, acc);
    chk("bp_wbc", 32'(wbc1), 32'd4);
    chk("bp_rdy", 32'(rdy1), 32'd0);
    cyc(1, 1'b1, 1'b1, 5'd5, 32'h105,
        32'h3000_0014, 1'b1, acc);
    chk("bp_acc_full", 32'(acc), 32'd0);
    chk("bp_wbc3", 32'(wbc1), 32'd3);
    chk("bp_rdy1", 32'(rdy1), 32'd1);
    cyc(1, 1'b1, 1'b1, 5'd5, 32'h105,
        32'h3000_0014, 1'b0, acc);
    chk("bp_acc5", 32'(acc), 32'd1);
    repeat (4) idle(1, 1'b1);
    chk("bp_rf5", u1.rf[5], 32'h105);

    // reset mid-traffic
    req(1, 1'b1, 5'd5, 32'h55, 32'h3000_0040, 1'b0);
    req(1, 1'b1, 5'd6, 32'h66, 32'h3000_0044, 1'b0);
    rd(1, 5'd5, 32'h55, "fwd_x5");
    reset1 = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset1 = 0;
    mreset(1);
    chk("mid_pc", pc1, 32'h3000_0000);
    chk("mid_wbc", 32'(wbc1), 32'd0);
    chk("mid_rc", rc1, 32'd0);
    chk("mid_rdy", 32'(rdy1), 32'd1);
    rd(1, 5'd5, 32'd0, "mid_x5");
    repeat (2) idle(1, 1'b1);
    chk("mid_pc2", pc1, 32'h3000_0000);
    chk("mid_rc2", rc1, 32'd0);

    // forwarding youngest entry
    req(1, 1'b1, 5'd3, 32'hA, 32'h3000_0100, 1'b0);
    req(1, 1'b1, 5'd3, 32'hB, 32'h3000_0104, 1'b0);
    rd(1, 5'd3, 32'hB, "fwd_x3");
    chk("fwd_rf3_0", u1.rf[3], 32'd0);
    idle(1, 1'b1);
    chk("fwd_rf3_a", u1.rf[3], 32'hA);
    rd(1, 5'd3, 32'hB, "fwd_x3b");
    idle(1, 1'b1);
    chk("fwd_rf3_b", u1.rf[3], 32'hB);

    // x0 and aliasing
    req(1, 1'b1, 5'd0, 32'hDEAD, 32'h3000_0200, 1'b0);
    req(1, 1'b1, 5'd16, 32'hDEAD, 32'h3000_0204, 1'b0);
    rd(1, 5'd0, 32'd0, "x0_rd");
    rd(1, 5'd16, 32'd0, "x16_rd");
    repeat (2) idle(1, 1'b1);
    chk("x0_pc", pc1, 32'h3000_0204);
    chk("x0_rf0", u1.rf[0], 32'd0);
    req(1, 1'b1, 5'd7, 32'h77, 32'h3000_0208, 1'b1);
    idle(1, 1'b1);
    rcb = mrc1;
    req(1, 1'b0, 5'd7, 32'h99, 32'h3000_020C, 1'b0);
    rd(1, 5'd7, 32'h77, "nowen_rd");
    idle(1, 1'b1);
    chk("nowen_rf7", u1.rf[7], 32'h77);
    chk("nowen_rc", rc1, rcb + 32'd1);

    // simultaneous push/retire across pointer wrap
    req(1, 1'b1, 5'd8, 32'h800, 32'h3000_0300, 1'b0);
    req(1, 1'b1, 5'd9, 32'h900, 32'h3000_0304, 1'b0);
    for (int k = 0; k < 10; k++) begin
      rcb = mrc1;
      cyc(1, 1'b1, 1'b1, 5'(8 + k % 6),
          32'h1000 + 32'(k), 32'h3000_0400 + 32'(4 * k),
          1'b1, acc);
      chk("sim_wbc", 32'(wbc1), 32'd2);
      chk("sim_rc", rc1, rcb + 32'd1);
    end
    repeat (2) idle(1, 1'b1);
    chk("sim_pc", pc1, 32'h3000_0424);
    chk("sim_rf13", u1.rf[13], 32'h1005);
    chk("sim_rf9", u1.rf[9], 32'h1007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24090012_regfile_wbq.md
# ysyx_24090012_regfile_wbq

Parametrised successor to the core's architectural register file. It accepts write-back requests from EXU through a valid/ready handshake into a write-back queue of configurable depth, and retires one queued entry per enabled cycle into the register array and the committed PC. Reads forward from pending queue entries, so IDU never sees stale data. With `WB_DEPTH=1` and `commit_en` tied high, it is cycle-equivalent to the current two-state register file.

## Interface
- `ADDR_WIDTH`, 5: register address width on all ports.
- `DATA_WIDTH`, 32: register data width.
- `NREG`, 16: implemented registers; power of two, 16 (RV32E) or 32; index = low log2(NREG) address bits.
- `WB_DEPTH`, 1: write-back queue entries, 1..8.
- `RESET_PC`, 32'h3000_0000: committed PC after reset.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `rd_valid`  in  1  EXU write-back request valid.
- `rd_ready`  out  1  queue can accept; reset value 1.
- `wen`  in  1  request writes a register (0 = PC-only retire).
- `waddr`  in  ADDR_WIDTH  destination register.
- `wdata`  in  DATA_WIDTH  destination data.
- `next_pc`  in  32  PC committed when the entry retires.
- `commit_en`  in  1  allow head entry to retire this cycle.
- `raddr1`, `raddr2`  in  ADDR_WIDTH  read addresses.
- `rdata1`, `rdata2`  out  DATA_WIDTH  combinational read data.
- `pc`  out  32  committed PC; reset `RESET_PC`.
- `wb_count`  out  clog2(WB_DEPTH+1)  queued entries; reset 0.
- `retire_cnt`  out  32  retired entries since reset, wraps at 2^32; reset 0.

## Operation
- Queue: circular FIFO of {wen, waddr, wdata, next_pc}. Head/tail pointers wrap modulo `WB_DEPTH`.
- Push: `rd_valid && rd_ready` at posedge → entry written at tail.
- `rd_ready = (wb_count < WB_DEPTH)`. This depends on registered count only, with no combinational path from `commit_en` or pop.
- Retire: `commit_en && wb_count != 0` at posedge.
  - `pc <= head.next_pc`.
  - `retire_cnt++`.
  - If `head.wen && index != 0`, `rf[index] <= head.wdata`.
  - Head advances.
- Push and retire in the same cycle: both occur and `wb_count` is unchanged. An entry pushed this edge cannot retire before the next edge.
- Index 0 is hardwired zero:
  - Writes to it are dropped.
  - Reads of it return 0, including forwarding.
  - Address bits above log2(NREG) are ignored, so address 16 aliases x0 when NREG=16.
- Read forwarding: `rdataN` returns wdata of the youngest queued entry with `wen=1` and matching index. Otherwise it returns `rf[index]`. In-flight requests (not yet pushed) are not forwarded.
- Reset:
  - Clears the queue (pointers and count).
  - Clears all `rf` entries to 0.
  - Sets `pc=RESET_PC` and `retire_cnt=0`.
  - Reset mid-operation discards pending entries without retiring them.
- DPI export `get_reg_value(int idx)` returns `rf[idx]` (committed value, no forwarding). It is guarded by the simulation-only define used for synthesis builds.

## Timing
- Push at edge N → earliest retire at edge N+1 (`commit_en` high). `pc`/`rf` visible after N+1.
- Forwarded read valid in the cycle after edge N (same cycle as queued).
- `WB_DEPTH=1`, `commit_en=1`:
  - `rd_ready` pattern is 1,0,1,0 under back-to-back valid.
  - Each accepted request commits exactly one cycle later.
- `WB_DEPTH=D`, `commit_en=0`: exactly D pushes are accepted, then `rd_ready=0` until a retire edge. The first cycle after that retire shows `rd_ready=1`.
- Full with `commit_en=1` and `rd_valid=1`: retire only on that edge, no push. The push happens on the next edge.
- Reads are purely combinational; no read latency.

## Test plan
- Reset sequencing: assert reset 2 cycles mid-traffic →
  - `pc=32'h3000_0000`, `wb_count=0`, `retire_cnt=0`, `rd_ready=1`.
  - `rdata1` for x5 = 0; no queued write retires afterwards.
- Depth 1 parity: 4 back-to-back writes (x1..x4 = 0x11..0x44, next_pc 0x3000_0004 step 4) →
  - `rd_ready` toggles 1,0,1,0.
  - Final `pc=0x3000_0010`, `rf[4]=0x44`, `retire_cnt=4`.
- Backpressure, `WB_DEPTH=4`, `commit_en=0`: push 5 requests →
  - 4 accepted; `rd_ready=0`, `wb_count=4`.
  - Raise `commit_en` for 1 cycle → `wb_count=3`; the 5th request is accepted the following edge.
- Forwarding: queue x3=0xA then x3=0xB with `commit_en=0` → `rdata1(raddr1=3)=0xB`. `get_reg_value(3)=0` until retire, then 0xA, then 0xB.
- x0/aliasing, NREG=16:
  - Write 0xDEAD to addr 0 and addr 16 → `rdata` for addrs 0/16 = 0; `pc` still updates.
  - Write with `wen=0` to x7 → `rf[7]` unchanged, `retire_cnt` increments.
- Simultaneous push/retire with `wb_count=2`, DEPTH 4 → `wb_count` stays 2, `retire_cnt+1`, FIFO order preserved across pointer wrap (≥9 pushes total).
